// File: rtl/ll_rd_ctrl_ptr_return.sv
// Pop/read controller for the linked list.
// Owns the head pointer and the node count. On a pop it reads the head node's data
// and next-pointer and presents the data to the consumer. When the consumer accepts,
// it advances the head and hands the freed pointer back to the allocator.
module ll_rd_ctrl_ptr_return #(
  parameter int DATA_WD       = 32,
  parameter int DATAMEM_DEPTH = 16,
  parameter int PTR_WD        = $clog2(DATAMEM_DEPTH),
  parameter int MEM_RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PTR_WD-1:0]  hdptr_cfg_value,
  input  logic               hdptr_cfg_value_vld,
  input  logic               node_appended,
  input  logic               make_ll_empty,
  input  logic               pop_req,
  output logic               pop_err,
  output logic               rd_busy,
  output logic               mem_rd_en,
  output logic [PTR_WD-1:0]  mem_rd_addr,
  input  logic [DATA_WD-1:0] datamem_rd_data,
  input  logic [PTR_WD-1:0]  nxtptrmem_rd_data,
  output logic [DATA_WD-1:0] rd_data,
  output logic               rd_data_vld,
  input  logic               rd_data_rdy,
  output logic               return_nxt_ptr,
  output logic [PTR_WD-1:0]  pos_2_return_nxt_ptr,
  output logic [PTR_WD-1:0]  hdptr_out,
  output logic [PTR_WD:0]    ll_node_cnt
);

  localparam int                WC_W      = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(MEM_RD_LAT - 1);
  localparam logic [PTR_WD:0]   CNT_MAX   = (PTR_WD + 1)'(DATAMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RESP     = 2'd3
  } state_e;

  state_e             state_q;
  logic [PTR_WD-1:0]  hdptr_q;
  logic [PTR_WD-1:0]  nxtptr_q;
  logic [DATA_WD-1:0] rd_data_q;
  logic               rd_data_vld_q;
  logic               mem_rd_en_q;
  logic               pop_err_q;
  logic               ret_q;
  logic [PTR_WD-1:0]  ret_pos_q;
  logic [WC_W-1:0]    wait_q;
  logic [PTR_WD:0]    cnt_q;
  logic [PTR_WD:0]    cnt_d;
  logic               accept;

  // Consumer handshake completing the popped node.
  assign accept = (state_q == RESP) && rd_data_vld_q && rd_data_rdy;

  // Pop sequencer: issue read, wait fixed latency, hold response, retire node.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hdptr_q       <= '0;
      nxtptr_q      <= '0;
      rd_data_q     <= '0;
      rd_data_vld_q <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      pop_err_q     <= 1'b0;
      ret_q         <= 1'b0;
      ret_pos_q     <= '0;
      wait_q        <= '0;
    end else begin
      pop_err_q   <= 1'b0;
      mem_rd_en_q <= 1'b0;
      ret_q       <= 1'b0;
      if (make_ll_empty) begin
        // Flush: abandon any pop; the allocator reclaims every pointer itself.
        state_q       <= IDLE;
        rd_data_vld_q <= 1'b0;
        wait_q        <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (hdptr_cfg_value_vld) begin
              hdptr_q <= hdptr_cfg_value;
            end
            if (pop_req) begin
              if (cnt_q == '0) begin
                pop_err_q <= 1'b1;
              end else begin
                state_q     <= RD_ISSUE;
                mem_rd_en_q <= 1'b1;
              end
            end
          end
          RD_ISSUE: begin
            state_q <= RD_WAIT;
            wait_q  <= '0;
          end
          RD_WAIT: begin
            if (wait_q == WAIT_LAST) begin
              rd_data_q     <= datamem_rd_data;
              nxtptr_q      <= nxtptrmem_rd_data;
              rd_data_vld_q <= 1'b1;
              state_q       <= RESP;
            end else begin
              wait_q <= wait_q + 1'b1;
            end
          end
          RESP: begin
            if (accept) begin
              ret_q         <= 1'b1;
              ret_pos_q     <= hdptr_q;
              hdptr_q       <= nxtptr_q;
              rd_data_vld_q <= 1'b0;
              state_q       <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Node count: appends saturate at depth, a simultaneous append and retire cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (make_ll_empty) begin
      cnt_d = '0;
    end else if (node_appended && !accept) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (accept && !node_appended) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Node count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pop_err              = pop_err_q;
  assign rd_busy              = (state_q != IDLE);
  assign mem_rd_en            = mem_rd_en_q;
  assign mem_rd_addr          = hdptr_q;
  assign rd_data              = rd_data_q;
  assign rd_data_vld          = rd_data_vld_q;
  assign return_nxt_ptr       = ret_q;
  assign pos_2_return_nxt_ptr = ret_pos_q;
  assign hdptr_out            = hdptr_q;
  assign ll_node_cnt          = cnt_q;

endmodule

// File: tb/tb_ll_rd_ctrl_ptr_return.sv
// Bench for ll_rd_ctrl_ptr_return: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based reference model.
module tb_ll_rd_ctrl_ptr_return;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
  localparam int LAT   = 1;

  logic          clk;
  logic          reset_n;
  logic [PW-1:0] hdptr_cfg_value;
  logic          hdptr_cfg_value_vld;
  logic          node_appended;
  logic          make_ll_empty;
  logic          pop_req;
  logic          pop_err;
  logic          rd_busy;
  logic          mem_rd_en;
  logic [PW-1:0] mem_rd_addr;
  logic [DW-1:0] datamem_rd_data;
  logic [PW-1:0] nxtptrmem_rd_data;
  logic [DW-1:0] rd_data;
  logic          rd_data_vld;
  logic          rd_data_rdy;
  logic          return_nxt_ptr;
  logic [PW-1:0] pos_2_return_nxt_ptr;
  logic [PW-1:0] hdptr_out;
  logic [PW:0]   ll_node_cnt;

  ll_rd_ctrl_ptr_return #(
    .DATA_WD(DW), .DATAMEM_DEPTH(DEPTH), .PTR_WD(PW), .MEM_RD_LAT(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .hdptr_cfg_value(hdptr_cfg_value), .hdptr_cfg_value_vld(hdptr_cfg_value_vld),
    .node_appended(node_appended), .make_ll_empty(make_ll_empty),
    .pop_req(pop_req), .pop_err(pop_err), .rd_busy(rd_busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .datamem_rd_data(datamem_rd_data), .nxtptrmem_rd_data(nxtptrmem_rd_data),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_data_rdy(rd_data_rdy),
    .return_nxt_ptr(return_nxt_ptr), .pos_2_return_nxt_ptr(pos_2_return_nxt_ptr),
    .hdptr_out(hdptr_out), .ll_node_cnt(ll_node_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories: one-cycle registered read; bus carries junk when not reading.
  logic [DW-1:0] dmem [DEPTH];
  logic [PW-1:0] nmem [DEPTH];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      datamem_rd_data   <= dmem[mem_rd_addr];
      nxtptrmem_rd_data <= nmem[mem_rd_addr];
    end else begin
      datamem_rd_data   <= $urandom;
      nxtptrmem_rd_data <= PW'($urandom);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: expected outputs for the current cycle.
  int          m_cnt, m_head, m_age, m_nxt, m_pos;
  bit          m_pop, m_vld, m_ret, m_err, m_rden;
  logic [DW-1:0] m_data;

  logic [DW-1:0] data_q[$];
  int            ret_q[$];

  task automatic model_reset();
    m_cnt = 0; m_head = 0; m_age = 0; m_nxt = 0; m_pos = 0;
    m_pop = 0; m_vld = 0; m_ret = 0; m_err = 0; m_rden = 0; m_data = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit acc, n_err, n_ret, n_rden;
    int cnt_n;
    acc = m_vld && rd_data_rdy;
    n_err = 0; n_ret = 0; n_rden = 0;
    if (make_ll_empty) begin
      m_pop = 0; m_vld = 0; m_cnt = 0; m_age = 0;
    end else begin
      cnt_n = m_cnt + int'(node_appended) - int'(acc);
      if (cnt_n > DEPTH) cnt_n = DEPTH;
      if (!m_pop) begin
        if (pop_req && m_cnt == 0) n_err = 1;
        else if (pop_req) begin m_pop = 1; m_age = 1; n_rden = 1; end
        if (hdptr_cfg_value_vld) m_head = int'(hdptr_cfg_value);
      end else if (acc) begin
        n_ret = 1; m_pos = m_head; m_head = m_nxt; m_pop = 0; m_vld = 0;
      end else begin
        m_age++;
        if (m_age == LAT + 2) begin
          m_vld = 1; m_data = dmem[m_head]; m_nxt = int'(nmem[m_head]);
        end
      end
      m_cnt = cnt_n;
    end
    m_err = n_err; m_ret = n_ret; m_rden = n_rden;
  endtask

  task automatic check_outputs();
    chk("rd_busy", rd_busy, m_pop);
    chk("mem_rd_en", mem_rd_en, m_rden);
    if (m_rden) chk("mem_rd_addr", mem_rd_addr, m_head);
    chk("rd_data_vld", rd_data_vld, m_vld);
    chk("rd_data", rd_data, m_data);
    chk("pop_err", pop_err, m_err);
    chk("return_nxt_ptr", return_nxt_ptr, m_ret);
    chk("pos_2_return", pos_2_return_nxt_ptr, m_pos);
    chk("hdptr_out", hdptr_out, m_head);
    chk("ll_node_cnt", ll_node_cnt, m_cnt);
  endtask

  // One clock: model follows the driven inputs, then outputs are checked at negedge.
  task automatic cycle();
    if (rd_data_vld && rd_data_rdy) data_q.push_back(rd_data);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk);
    cyc++;
    if (return_nxt_ptr) ret_q.push_back(int'(pos_2_return_nxt_ptr));
    check_outputs();
  endtask

  task automatic quiet();
    hdptr_cfg_value_vld = 0; node_appended = 0; make_ll_empty = 0; pop_req = 0;
  endtask

  task automatic cfg_head(input int h);
    hdptr_cfg_value = PW'(h); hdptr_cfg_value_vld = 1; cycle(); quiet();
  endtask

  task automatic appends(input int n);
    for (int i = 0; i < n; i++) begin node_appended = 1; cycle(); end
    quiet();
  endtask

  // Issue a pop and wait (bounded) until rd_data_vld; returns cycles from pop_req.
  task automatic pop_wait(input bit rdy, output int lat);
    pop_req = 1; rd_data_rdy = rdy; cycle(); quiet();
    lat = 1;
    while (!rd_data_vld && lat < 20) begin cycle(); lat++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int lat, nret;
    reset_n = 0; rd_data_rdy = 0; hdptr_cfg_value = '0; quiet();
    for (int i = 0; i < DEPTH; i++) begin dmem[i] = $urandom; nmem[i] = PW'($urandom); end
    model_reset();
    // Test 1: reset, then 20 idle cycles with every output low.
    cycle(); cycle();
    reset_n = 1;
    for (int i = 0; i < 20; i++) cycle();

    // Test 2: chain 5->9->2, three pops with rdy held high.
    dmem[5] = 32'hA5; nmem[5] = 4'd9;
    dmem[9] = 32'hA9; nmem[9] = 4'd2;
    dmem[2] = 32'hA2; nmem[2] = 4'd7;
    cfg_head(5);
    appends(3);
    chk("t2_cnt_start", ll_node_cnt, 3);
    data_q.delete(); ret_q.delete();
    for (int p = 0; p < 3; p++) begin
      pop_wait(1'b1, lat);
      chk("t2_latency", lat, 3);
      cycle();
    end
    rd_data_rdy = 0;
    cycle();
    chk("t2_npops", data_q.size(), 3);
    chk("t2_nrets", ret_q.size(), 3);
    if (data_q.size() == 3) begin
      chk("t2_data0", data_q[0], 32'hA5);
      chk("t2_data1", data_q[1], 32'hA9);
      chk("t2_data2", data_q[2], 32'hA2);
    end
    if (ret_q.size() == 3) begin
      chk("t2_ret0", ret_q[0], 5);
      chk("t2_ret1", ret_q[1], 9);
      chk("t2_ret2", ret_q[2], 2);
    end
    chk("t2_cnt_end", ll_node_cnt, 0);

    // Test 3: pop on empty list.
    pop_req = 1; cycle(); quiet();
    chk("t3_pop_err", pop_err, 1);
    chk("t3_busy", rd_busy, 0);
    cycle();
    chk("t3_pop_err_gone", pop_err, 0);

    // Test 4: consumer stalls four cycles in RESP.
    cfg_head(5);
    appends(1);
    pop_wait(1'b0, lat);
    chk("t4_vld_seen", rd_data_vld, 1);
    for (int i = 0; i < 4; i++) cycle();
    chk("t4_data_held", rd_data, 32'hA5);
    chk("t4_no_ret", return_nxt_ptr, 0);
    rd_data_rdy = 1; cycle(); rd_data_rdy = 0;
    chk("t4_ret", return_nxt_ptr, 1);
    chk("t4_pos", pos_2_return_nxt_ptr, 5);
    chk("t4_cnt", ll_node_cnt, 0);
    cycle();
    chk("t4_ret_single", return_nxt_ptr, 0);

    // Test 5a: flush while waiting on the memory.
    cfg_head(5);
    appends(2);
    pop_req = 1; cycle(); quiet();
    cycle();
    make_ll_empty = 1; cycle(); quiet();
    chk("t5_busy", rd_busy, 0);
    chk("t5_cnt", ll_node_cnt, 0);
    chk("t5_vld", rd_data_vld, 0);
    nret = ret_q.size();
    rd_data_rdy = 1;
    for (int i = 0; i < 5; i++) cycle();
    rd_data_rdy = 0;
    chk("t5_no_ret", ret_q.size(), nret);

    // Test 5b: reset asserted while holding a response.
    appends(2);
    pop_wait(1'b0, lat);
    reset_n = 0;
    #1;
    model_reset();
    check_outputs();
    chk("t5r_vld", rd_data_vld, 0);
    cycle();
    reset_n = 1;
    nret = ret_q.size();
    rd_data_rdy = 1;
    for (int i = 0; i < 4; i++) cycle();
    rd_data_rdy = 0;
    chk("t5r_no_ret", ret_q.size(), nret);
    chk("t5r_cnt", ll_node_cnt, 0);

    // Test 6: append coinciding with accept, then saturation.
    cfg_head(5);
    appends(2);
    pop_wait(1'b0, lat);
    node_appended = 1; rd_data_rdy = 1; cycle(); quiet(); rd_data_rdy = 0;
    chk("t6_cnt_same", ll_node_cnt, 2);
    make_ll_empty = 1; cycle(); quiet();
    appends(DEPTH + 1);
    chk("t6_cnt_sat", ll_node_cnt, DEPTH);

    // Random traffic.
    make_ll_empty = 1; cycle(); quiet();
    for (int i = 0; i < DEPTH; i++) begin dmem[i] = $urandom; nmem[i] = PW'($urandom); end
    for (int i = 0; i < 1500; i++) begin
      pop_req             = ($urandom_range(0, 3) == 0);
      node_appended       = ($urandom_range(0, 2) == 0);
      rd_data_rdy         = $urandom_range(0, 1);
      hdptr_cfg_value_vld = ($urandom_range(0, 7) == 0);
      hdptr_cfg_value     = PW'($urandom);
      make_ll_empty       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    quiet(); rd_data_rdy = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
